// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register offsets,
// mode codes, FSM state encoding, CTRL field layout and a guarded decrement helper.
package timer_counter_pkg;

  localparam int DATA_W = 32;

  // Word offsets seen through the system bridge
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  localparam logic [1:0] TC_ONESHOT = 2'b00;
  localparam logic [1:0] TC_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Unsigned decrement that saturates at zero so COUNT can never wrap
  function automatic logic [DATA_W-1:0] tc_sat_dec(input logic [DATA_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counter timer: CTRL/PRESET/COUNT register file, a 4-state FSM and
// an interrupt request (pending masked by CTRL.IM) feeding CP0 HWInt[0].
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  tc_state_e         r_state;
  tc_ctrl_t          r_ctrl;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] r_count;
  logic              r_pending;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_reload_mode;
  logic w_unused_din;

  assign w_wr_ctrl     = we && (addr == TC_CTRL);
  assign w_wr_preset   = we && (addr == TC_PRESET);
  assign w_reload_mode = (r_ctrl.mode == TC_RELOAD);
  assign w_unused_din  = ^din[DATA_W-1:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= TC_IDLE;
      r_ctrl    <= '0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_preset) begin
        r_preset <= din;
      end

      case (r_state)
        TC_IDLE: begin
          if (r_ctrl.en) begin
            r_state <= TC_LOAD;
          end
        end
        TC_LOAD: begin
          r_count <= r_preset;
          r_state <= TC_CNT;
        end
        TC_CNT: begin
          if (!r_ctrl.en) begin
            r_state <= TC_IDLE;
          end else if (r_count != '0) begin
            r_count <= tc_sat_dec(r_count);
          end else begin
            r_state   <= TC_INT;
            r_pending <= 1'b1;
          end
        end
        TC_INT: begin
          // Reserved modes 2/3 fall through to one-shot behaviour
          if (w_reload_mode) begin
            r_state   <= TC_LOAD;
            r_pending <= 1'b0;
          end else begin
            r_state   <= TC_IDLE;
            r_ctrl.en <= 1'b0;
          end
        end
        default: r_state <= TC_IDLE;
      endcase

      // Placed last so a CPU write overrides the hardware Enable clear and pending set
      if (w_wr_ctrl) begin
        r_ctrl    <= tc_ctrl_t'(din[3:0]);
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      TC_CTRL:   dout = {{(DATA_W-4){1'b0}}, r_ctrl};
      TC_PRESET: dout = r_preset;
      TC_COUNT:  dout = r_count;
      TC_RSVD:   dout = '0;
      default:   dout = '0;
    endcase
  end

  assign irq = r_pending & r_ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: vector table for the one-shot path, directed corner
// sequences, and randomized traffic checked against a behavioural timer model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  always #5 clk = ~clk;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a timer that is either idle or busy; when busy it is
  // about to load, counting, or has just fired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_pending;
  bit          m_busy;
  bit          m_load;
  bit          m_fired;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [3:0]  c;
    logic [31:0] p;
    logic [31:0] n;
    bit pend, busy, load, fired;
    if (reset) begin
      m_ctrl = 0; m_preset = 0; m_count = 0;
      m_pending = 0; m_busy = 0; m_load = 0; m_fired = 0;
      return;
    end
    c = m_ctrl; p = m_preset; n = m_count;
    pend = m_pending; busy = m_busy; load = m_load; fired = m_fired;
    if (!m_busy) begin
      if (m_ctrl[0]) begin busy = 1; load = 1; end
    end else if (m_load) begin
      n = m_preset; load = 0;
    end else if (m_fired) begin
      fired = 0;
      if (m_ctrl[2:1] == 2'b01) begin load = 1; pend = 0; end
      else begin busy = 0; c[0] = 1'b0; end
    end else if (!m_ctrl[0]) begin
      busy = 0;
    end else if (m_count > 0) begin
      n = m_count - 1;
    end else begin
      fired = 1; pend = 1;
    end
    if (we && addr == 2'd1) p = din;
    if (we && addr == 2'd0) begin c = din[3:0]; pend = 0; end
    m_ctrl = c; m_preset = p; m_count = n;
    m_pending = pend; m_busy = busy; m_load = load; m_fired = fired;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge
  task automatic step(input bit r, input bit w, input logic [1:0] a,
                      input logic [31:0] d, input bit cmp);
    reset = r; we = w; addr = a; din = d;
    model_edge();
    @(posedge clk);
    #1;
    if (cmp) begin
      check("model_dout", dout, m_read(addr));
      check("model_irq", {31'd0, irq}, {31'd0, m_pending & m_ctrl[3]});
    end
  endtask

  typedef struct {
    bit          rst;
    bit          wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int hist_cnt[48];
    bit hist_irq[48];
    int pulses[$];
    int found;

    reset = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;

    // Reset, then one-shot PRESET=5 with CTRL=0x9 written at edge t
    tbl[0]  = '{1, 0, 2'd0, 32'd0,  32'd0, 0};
    tbl[1]  = '{1, 0, 2'd1, 32'd0,  32'd0, 0};
    tbl[2]  = '{1, 0, 2'd2, 32'd0,  32'd0, 0};
    tbl[3]  = '{1, 0, 2'd3, 32'd0,  32'd0, 0};
    tbl[4]  = '{0, 1, 2'd1, 32'd5,  32'd5, 0};
    tbl[5]  = '{0, 1, 2'd0, 32'd9,  32'd9, 0};   // t
    tbl[6]  = '{0, 0, 2'd2, 32'd0,  32'd0, 0};   // t+1 load pending
    tbl[7]  = '{0, 0, 2'd2, 32'd0,  32'd5, 0};   // t+2
    tbl[8]  = '{0, 1, 2'd2, 32'hFF, 32'd4, 0};   // COUNT write ignored
    tbl[9]  = '{0, 0, 2'd2, 32'd0,  32'd3, 0};
    tbl[10] = '{0, 1, 2'd3, 32'hAB, 32'd0, 0};   // offset 3 write ignored
    tbl[11] = '{0, 0, 2'd2, 32'd0,  32'd1, 0};
    tbl[12] = '{0, 0, 2'd2, 32'd0,  32'd0, 0};   // t+7
    tbl[13] = '{0, 0, 2'd2, 32'd0,  32'd0, 1};   // t+8 irq rises
    tbl[14] = '{0, 0, 2'd0, 32'd0,  32'd8, 1};   // Enable auto-cleared
    tbl[15] = '{0, 0, 2'd0, 32'd0,  32'd8, 1};   // irq held
    tbl[16] = '{0, 0, 2'd2, 32'd0,  32'd0, 1};
    tbl[17] = '{0, 1, 2'd0, 32'd0,  32'd0, 0};   // CTRL write drops irq
    tbl[18] = '{0, 0, 2'd1, 32'd0,  32'd5, 0};
    tbl[19] = '{0, 0, 2'd3, 32'd0,  32'd0, 0};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0);
      check($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
      $display("vec %0d rst=%0b we=%0b addr=%0d din=0x%08h dout=0x%08h irq=%0b",
               i, tbl[i].rst, tbl[i].wr, tbl[i].a, tbl[i].d, dout, irq);
    end

    // Auto-reload, PRESET=3: pulse every 6 edges, COUNT 3,2,1,0 between pulses
    step(1, 0, 2'd0, 0, 1);
    step(0, 1, 2'd1, 32'd3, 1);
    step(0, 1, 2'd0, 32'hB, 1);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 2'd2, 0, 1);
      hist_cnt[i] = int'(dout);
      hist_irq[i] = irq;
      if (irq) pulses.push_back(i);
    end
    check("reload_pulses", pulses.size(), 6);
    if (pulses.size() >= 2) begin
      check("reload_first", pulses[0], 5);
      for (int k = 0; k + 1 < pulses.size(); k++)
        check($sformatf("reload_period%0d", k), pulses[k+1] - pulses[k], 6);
      check("reload_width", {31'd0, hist_irq[pulses[0]+1]}, 32'd0);
      check("reload_c3", hist_cnt[pulses[0]+2], 3);
      check("reload_c2", hist_cnt[pulses[0]+3], 2);
      check("reload_c1", hist_cnt[pulses[0]+4], 1);
      check("reload_c0", hist_cnt[pulses[0]+5], 0);
    end
    $display("reload pulses seen=%0d", pulses.size());

    // Masked one-shot: pending without irq, Enable clears, CTRL write clears pending
    step(1, 0, 2'd0, 0, 1);
    step(0, 1, 2'd1, 32'd2, 1);
    step(0, 1, 2'd0, 32'h1, 1);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 2'd0, 0, 1);
      if (irq) found = 1;
    end
    check("masked_irq", found, 0);
    check("masked_en_clear", dout, 32'd0);
    step(0, 1, 2'd0, 32'h8, 1);
    check("masked_im_write", {31'd0, irq}, 32'd0);
    $display("masked sequence ctrl=0x%08h irq=%0b", dout, irq);

    // Disable mid-count: COUNT freezes at 91, COUNT write ignored
    step(1, 0, 2'd0, 0, 1);
    step(0, 1, 2'd1, 32'd100, 1);
    step(0, 1, 2'd0, 32'h1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 2'd2, 0, 1);
    step(0, 1, 2'd0, 32'h8, 1);
    step(0, 0, 2'd2, 0, 1);
    check("disable_count", dout, 32'd91);
    for (int i = 0; i < 5; i++) step(0, 0, 2'd2, 0, 1);
    step(0, 1, 2'd2, 32'h1234, 1);
    check("disable_frozen", dout, 32'd91);
    $display("disable sequence count=%0d", dout);

    // Race: CPU writes CTRL=0x9 on the INT edge, Enable survives and timer reruns
    step(1, 0, 2'd0, 0, 1);
    step(0, 1, 2'd1, 32'd2, 1);
    step(0, 1, 2'd0, 32'h9, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 0, 1);
    step(0, 0, 2'd0, 0, 1);
    check("race_irq_rise", {31'd0, irq}, 32'd1);
    step(0, 1, 2'd0, 32'h9, 1);
    check("race_ctrl", dout, 32'd9);
    check("race_irq_clr", {31'd0, irq}, 32'd0);
    found = -1;
    for (int i = 0; i < 12 && found < 0; i++) begin
      step(0, 0, 2'd2, 0, 1);
      if (irq) found = i;
    end
    check("race_refire", found, 4);
    $display("race sequence refire step=%0d", found);

    // Reset mid-count
    step(1, 0, 2'd0, 0, 1);
    step(0, 1, 2'd1, 32'd50, 1);
    step(0, 1, 2'd0, 32'hB, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 2'd2, 0, 1);
    step(1, 0, 2'd2, 0, 1);
    check("rst_mid_count", dout, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    step(0, 0, 2'd0, 0, 1);
    check("rst_mid_ctrl", dout, 32'd0);
    step(0, 0, 2'd1, 0, 1);
    check("rst_mid_preset", dout, 32'd0);
    $display("reset-mid-count sequence done");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit r, w;
      logic [1:0] a;
      logic [31:0] d;
      r = ($urandom_range(0, 249) == 0);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd0) d = {$urandom_range(0, 1) ? 28'd0 : 28'($urandom), 4'($urandom_range(0, 15)) | 4'h1};
      else if (a == 2'd1) d = $urandom_range(0, 8);
      else d = $urandom;
      step(r, w, a, d, 1);
      if (w || r)
        $display("rand %0d rst=%0b we=%0b addr=%0d din=0x%08h dout=0x%08h irq=%0b",
                 i, r, w, a, d, dout, irq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
